// File: rtl/rr_mux4to1.sv
// Round-robin 4-to-1 valid/ready stream mux with one registered output stage.
// Define RR_MUX_FIXED_PRIO_EN for fixed priority (channel 0 highest) instead of round-robin.
module rr_mux4to1 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]        in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  input  logic              out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_sel_q, out_sel_d;
  logic [1:0]        start_idx;
  logic              found;
  logic [1:0]        win_idx;
  logic [DATA_W-1:0] win_data;
  logic              can_accept;
  logic              accept;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign start_idx = 2'd0;
`else
  logic [1:0] ptr_q, ptr_d;
  assign start_idx = ptr_q;
`endif

  // Search from start_idx upward, wrapping mod 4; first valid channel wins.
  always_comb begin
    logic [1:0] idx;
    found    = 1'b0;
    win_idx  = '0;
    win_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start_idx + 2'(i);
      if (!found && in_valid[idx]) begin
        found    = 1'b1;
        win_idx  = idx;
        win_data = in_data[int'(idx)*DATA_W +: DATA_W];
      end
    end
  end

  assign can_accept = !out_valid_q || out_ready;
  // rst gates the handshake so nothing is accepted while reset is asserted.
  assign accept     = found && can_accept && !rst;
  assign in_ready   = accept ? (4'b0001 << win_idx) : 4'b0000;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_sel_d   = win_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifndef RR_MUX_FIXED_PRIO_EN
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = win_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux4to1.sv
// Scoreboard bench for rr_mux4to1: driver pushes expected beats, monitor pops on consumption.
module tb_rr_mux4to1;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  logic [7:0]  chdata [4];
  logic [9:0]  sb [$];
  int          n_cmp;
  int          n_err;

  rr_mux4to1 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = chdata[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // One cycle of stimulus; exp_ir is the hand-computed grant, exp_ov the current out_valid.
  task automatic step(input logic [3:0] v, input logic r, input logic [3:0] exp_ir, input logic exp_ov);
    logic [1:0] s;
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = r;
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ir != 4'b0000) begin
      s = onehot_idx(exp_ir);
      sb.push_back({s, chdata[s]});
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got sel %0d data %0h expected none", out_sel, out_data);
      end else begin
        e = sb.pop_front();
        check("beat_sel", 32'(out_sel), 32'(e[9:8]));
        check("beat_data", 32'(out_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    chdata[0] = 8'h10; chdata[1] = 8'h11; chdata[2] = 8'h12; chdata[3] = 8'h13;
    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_hold", 32'(in_ready), 32'd0);
    in_valid = 4'b0000;
    rst = 1'b0;

    // Round-robin from ptr=0
    step(4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b1111, 1'b1, 4'b0010, 1'b1);
    step(4'b1111, 1'b1, 4'b0100, 1'b1);
    step(4'b1111, 1'b1, 4'b1000, 1'b1);
    step(4'b1111, 1'b1, 4'b0001, 1'b1);
    step(4'b1111, 1'b1, 4'b0010, 1'b1);
    step(4'b1111, 1'b1, 4'b0100, 1'b1);
    step(4'b1111, 1'b1, 4'b1000, 1'b1);

    // Backpressure: ch0 held for 3 stalled cycles, then ch1 next
    step(4'b1111, 1'b1, 4'b0001, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(4'b1111, 1'b0, 4'b0000, 1'b1);
      check("stall_sel", 32'(out_sel), 32'd0);
      check("stall_data", 32'(out_data), 32'h10);
    end
    step(4'b1111, 1'b1, 4'b0010, 1'b1);

    // Wrap and skip: ptr reaches 3, ch3 idle
    step(4'b0100, 1'b1, 4'b0100, 1'b1);
    step(4'b0101, 1'b1, 4'b0001, 1'b1);
    step(4'b0101, 1'b1, 4'b0100, 1'b1);

    // Single channel with ptr=3, then drain
    chdata[1] = 8'hA5;
    step(4'b0010, 1'b1, 4'b0010, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);
    check("drain_sel", 32'(out_sel), 32'd1);
    check("drain_data", 32'(out_data), 32'hA5);
    chdata[1] = 8'h11;

    // Reset mid-stream with a held beat
    step(4'b1000, 1'b1, 4'b1000, 1'b0);
    step(4'b1111, 1'b0, 4'b0000, 1'b1);
    #1;
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sel", 32'(out_sel), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    void'(sb.pop_front());
    @(posedge clk);
    #1;
    check("mid_rst_in_ready_edge", 32'(in_ready), 32'd0);
    in_valid = 4'b0100;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'b0100);
    sb.push_back({2'd2, chdata[2]});
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
